intt_core: RTL and testbench
============================

INTT_CORE -- requirements
Module: intt_core

Interface
REQ-001 Parameters SHALL be: N, default 256, polynomial length; Q, default 3329, modulus; CW, default 16, coefficient port width.
REQ-002 Ports SHALL be (name direction width meaning): clk input 1 sole clock, rising edge; reset input 1 asynchronous active-high reset.
REQ-003 in_valid input 1: in_coeff holds a valid coefficient.
REQ-004 in_coeff input CW: NTT-domain coefficient, streamed in index order 0..N-1 (pointwise-multiply product order).
REQ-005 in_ready output 1: block accepts a coefficient this cycle.
REQ-006 out_valid output 1: out_coeff is valid.
REQ-007 out_coeff output CW: normal-domain coefficient in [0,Q-1], index order 0..N-1, upper bits zero.
REQ-008 out_last output 1: high with coefficient N-1.
REQ-009 out_ready input 1: downstream accepts out_coeff.
REQ-010 busy output 1: high in COMPUTE and OUTPUT.

Function
REQ-011 FSM SHALL have exactly three states: LOAD, COMPUTE, OUTPUT.
REQ-012 LOAD: in_ready=1; a beat transfers when in_valid&in_ready; each beat stores in_coeff mod Q at load index; index increments 0..255.
REQ-013 The beat that transfers index 255 SHALL move the FSM to COMPUTE on the next edge; no 257th beat is accepted.
REQ-014 COMPUTE: one Gentleman-Sande butterfly per cycle, 7 layers (len=2,4,...,128), 128 butterflies per layer, exactly 896 cycles; in_ready=0, out_valid=0.
REQ-015 Butterfly order: k starts at 127; for each len, for start=0,2len,...: zeta=ZETAS[k], k decrements once per block; for j=start..start+len-1: t=f[j]; f[j]=(t+f[j+len]) mod Q; f[j+len]=(zeta*(f[j+len]-t)) mod Q, with the subtraction made non-negative by adding Q.
REQ-016 Butterfly SHALL read and write both f[j] and f[j+len] in the same cycle (register-array storage, combinational read).
REQ-017 All intermediate results SHALL be fully reduced to [0,Q-1]; products are 24 bits before reduction.
REQ-018 After the 896th butterfly the FSM SHALL enter OUTPUT; out_valid SHALL rise on that edge.
REQ-019 OUTPUT: out_coeff=(f[idx]*NINV) mod Q, NINV=3303; idx advances only on out_valid&out_ready; out_coeff and out_last SHALL stay stable while out_ready=0.
REQ-020 The transfer of idx 255 (out_last=1) SHALL return the FSM to LOAD with index 0 on the next edge; in_ready rises in that same cycle.
REQ-021 in_valid during COMPUTE/OUTPUT SHALL be ignored; out_ready outside OUTPUT SHALL have no effect.
REQ-022 in_coeff >= Q SHALL be reduced mod Q on load.

Reset
REQ-023 reset SHALL asynchronously force: FSM=LOAD, all counters and k to reset values (index 0, k=127, len=2), in_ready=1, out_valid=0, out_last=0, busy=0, out_coeff=0.
REQ-024 Coefficient storage SHALL NOT be reset; reset in any state, including mid-COMPUTE or mid-OUTPUT, SHALL abort the transform, with no further output beats until a full new 256-beat load completes.

Structure
REQ-025 Shared package kyber_pkg SHALL hold Q, N, NINV=3303, and the 128-entry ZETAS table (ZETAS[k]=17^BitRev7(k) mod Q).
REQ-026 One combinational sub-module intt_butterfly SHALL implement the REQ-015 butterfly (inputs a, b, zeta; outputs a', b', reduced).
REQ-027 The modular reduction SHALL be shared by the butterfly and output scaling via a package function.

Verification
REQ-028 Load f[2i]=1, f[2i+1]=0 for all i -> output 1 then 255 zeros; out_last on beat 255.
REQ-029 Load f[2i]=0, f[2i+1]=1 -> output [0,1,0,...,0]; load all zeros -> all zeros.
REQ-030 Timing: out_ready=1 always; last input beat at cycle T -> first out_valid at T+1+896; 256 consecutive output beats.
REQ-031 Random out_ready (~50%) and in_valid gaps, 20 random polynomials -> outputs match a software InvNTT model; out_coeff stable while stalled.
REQ-032 reset asserted at COMPUTE cycle 400 -> in_ready=1, busy=0 immediately; next full load produces the correct result for the new input only.
REQ-033 in_coeff=0xFFFF at all even indices, 0 at odd -> same result as loading 65535 mod 3329 = 2284 at those indices.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared Kyber constants and helpers.
//   Q, N, NINV : modulus, polynomial length, and N/2 inverse scale (128^-1 mod Q)
//   ZETAS      : 128-entry twiddle table, ZETAS[k] = 17^BitRev7(k) mod Q
//   mod_q()    : full reduction to [0, m-1], used by the butterfly and output scaling
package kyber_pkg;

  localparam int N    = 256;
  localparam int Q    = 3329;
  localparam int NINV = 3303;
  localparam int QW   = 12;      // width of a reduced coefficient

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_COMPUTE,
    ST_OUTPUT
  } state_t;

  typedef logic [127:0][QW-1:0] zeta_tab_t;

  // Reduce a 24-bit value into [0, m-1].
  function automatic logic [QW-1:0] mod_q(input logic [23:0] x, input logic [23:0] m);
    return QW'(x % m);
  endfunction

  // Walk the powers of 17 in order and drop each one at its bit-reversed slot,
  // so the table is built with one multiply per entry.
  function automatic zeta_tab_t gen_zetas();
    zeta_tab_t   tab;
    int unsigned p;
    logic [6:0]  e;
    logic [6:0]  br;
    tab = '0;
    p   = 1;
    br  = '0;
    for (int i = 0; i < 128; i++) begin
      e = 7'(i);
      for (int b = 0; b < 7; b++) br[b] = e[6-b];
      tab[br] = QW'(p);
      p = (p * 17) % Q;
    end
    return tab;
  endfunction

  localparam zeta_tab_t ZETAS = gen_zetas();

endpackage

// File: rtl/intt_butterfly.sv
// Combinational Gentleman-Sande butterfly.
//   a, b    : input coefficients in [0,Q-1]
//   zeta    : twiddle factor
//   a_out   : (a + b) mod Q
//   b_out   : zeta * (b - a) mod Q
module intt_butterfly #(
  parameter int Q = kyber_pkg::Q
) (
  input  logic [kyber_pkg::QW-1:0] a,
  input  logic [kyber_pkg::QW-1:0] b,
  input  logic [kyber_pkg::QW-1:0] zeta,
  output logic [kyber_pkg::QW-1:0] a_out,
  output logic [kyber_pkg::QW-1:0] b_out
);
  import kyber_pkg::*;

  logic [QW-1:0] diff;
  logic [23:0]   prod;

  always_comb begin
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    diff  = '0;
    prod  = '0;
    a_out = mod_q(24'(a) + 24'(b), 24'(Q));
    // Difference is brought into [0,Q-1] before the multiply so the product
    // stays within 24 bits. The b<a branch wraps in QW bits but the true
    // result is below Q, so the wrap cancels out.
    if (b >= a) diff = b - a;
    else        diff = b + QW'(Q) - a;
    prod  = 24'(zeta) * 24'(diff);
    b_out = mod_q(prod, 24'(Q));
  end

endmodule

// File: rtl/intt_core.sv
// Streaming Kyber inverse NTT.
//   clk, reset           : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    : NTT-domain coefficient stream, index 0..N-1
//   in_coeff             : input coefficient (reduced mod Q on load)
//   out_valid/out_ready  : normal-domain coefficient stream, index 0..N-1
//   out_coeff, out_last  : output coefficient in [0,Q-1]; out_last marks N-1
//   busy                 : transform in progress (COMPUTE or OUTPUT)
// LOAD fills the register array, COMPUTE runs one butterfly per cycle for
// 7 layers x 128 butterflies, OUTPUT streams f[i]*NINV mod Q.
module intt_core #(
  parameter int N  = kyber_pkg::N,
  parameter int Q  = kyber_pkg::Q,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [CW-1:0] in_coeff,
  output logic          in_ready,
  output logic          out_valid,
  output logic [CW-1:0] out_coeff,
  output logic          out_last,
  input  logic          out_ready,
  output logic          busy
);
  import kyber_pkg::*;

  localparam int IW = $clog2(N);

  logic [QW-1:0] f [N];

  state_t        state;
  logic [IW-1:0] idx;       // load index in LOAD, output index in OUTPUT
  logic [IW-1:0] len_r;     // butterfly span of the current layer
  logic [IW-1:0] start_r;   // first index of the current block
  logic [IW-1:0] joff;      // offset of j within the block
  logic [6:0]    k_r;       // twiddle index, counts down once per block

  logic [IW-1:0] j_lo, j_hi, nxt_idx;
  logic [IW:0]   nxt_start;
  logic          blk_end, layer_end, last_layer;
  logic          load_fire, out_fire;
  logic [QW-1:0] bf_a, bf_b, in_red, scaled_first, scaled_next;

  assign j_lo       = start_r + joff;
  assign j_hi       = j_lo + len_r;
  assign nxt_idx    = idx + IW'(1);
  assign nxt_start  = {1'b0, start_r} + {len_r, 1'b0};
  assign blk_end    = (joff == len_r - IW'(1));
  assign layer_end  = (nxt_start == (IW+1)'(N));
  assign last_layer = (len_r == IW'(N / 2));
  assign load_fire  = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;

  assign in_red       = mod_q(24'(in_coeff), 24'(Q));
  assign scaled_first = mod_q(24'(f[0]) * 24'(NINV), 24'(Q));
  assign scaled_next  = mod_q(24'(f[nxt_idx]) * 24'(NINV), 24'(Q));

  intt_butterfly #(.Q(Q)) u_butterfly (
    .a     (f[j_lo]),
    .b     (f[j_hi]),
    .zeta  (ZETAS[k_r]),
    .a_out (bf_a),
    .b_out (bf_b)
  );

  // NOTE: the coefficient array has no reset; a fresh load overwrites every
  // entry before it is read, so resetting it would only add fan-out.
  always_ff @(posedge clk) begin
    if (state == ST_LOAD && load_fire) begin
      f[idx] <= in_red;
    end else if (state == ST_COMPUTE) begin
      f[j_lo] <= bf_a;
      f[j_hi] <= bf_b;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_LOAD;
      idx       <= '0;
      len_r     <= IW'(2);
      start_r   <= '0;
      joff      <= '0;
      k_r       <= 7'd127;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_coeff <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (load_fire) begin
            idx <= nxt_idx;   // wraps to 0 after the last beat
            if (idx == IW'(N - 1)) begin
              state    <= ST_COMPUTE;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end

        ST_COMPUTE: begin
          if (blk_end) begin
            joff <= '0;
            k_r  <= k_r - 7'd1;
            if (layer_end) begin
              start_r <= '0;
              len_r   <= len_r << 1;
            end else begin
              start_r <= nxt_start[IW-1:0];
            end
          end else begin
            joff <= joff + IW'(1);
          end
          if (blk_end && layer_end && last_layer) begin
            // f[0] was finalised early in the last layer, so it is safe to
            // scale it on the same edge as the final butterfly.
            state     <= ST_OUTPUT;
            len_r     <= IW'(2);
            k_r       <= 7'd127;
            out_valid <= 1'b1;
            out_coeff <= CW'(scaled_first);
            out_last  <= 1'b0;
          end
        end

        ST_OUTPUT: begin
          if (out_fire) begin
            if (out_last) begin
              state     <= ST_LOAD;
              idx       <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_coeff <= '0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              idx       <= nxt_idx;
              out_coeff <= CW'(scaled_next);
              out_last  <= (nxt_idx == IW'(N - 1));
            end
          end
        end

        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_intt_core.sv
// Bench for intt_core: pair-pattern vectors with hand-derived results,
// random polynomials against a software inverse NTT, timing and reset cases.
module tb_intt_core;

  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_coeff;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_coeff;
  logic        out_last;
  logic        out_ready;
  logic        busy;

  intt_core dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_coeff  (in_coeff),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_coeff (out_coeff),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    even_in;
    int    odd_in;
    int    exp0;
    int    exp1;
  } vec_t;

  vec_t vecs[8];
  int   zt[128];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Reference inverse NTT (textbook loop) with final 128^-1 scaling.
  function automatic void inv_ntt(input int a[256], output int r[256]);
    int f[256];
    int k;
    int t;
    k = 127;
    for (int i = 0; i < 256; i++) f[i] = a[i] % Q;
    for (int len = 2; len <= 128; len = len * 2) begin
      for (int start = 0; start < 256; start = start + 2 * len) begin
        int z;
        z = zt[k];
        k--;
        for (int j = start; j < start + len; j++) begin
          t          = f[j];
          f[j]       = (t + f[j+len]) % Q;
          f[j+len]   = (z * (f[j+len] - t + Q)) % Q;
        end
      end
    end
    for (int i = 0; i < 256; i++) r[i] = (f[i] * 3303) % Q;
  endfunction

  // Drives all 256 beats; t_last is the cycle whose edge takes beat 255.
  task automatic load_poly(input int c[256], input bit gaps, output int t_last);
    int i;
    int budget;
    bit v;
    i = 0;
    budget = 0;
    t_last = -1;
    while (i < 256 && budget < 2000) begin
      budget++;
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid = v;
      in_coeff = 16'(c[i]);
      if (v && in_ready) begin
        t_last = cyc;
        i++;
      end
      tick();
    end
    in_valid = 1'b0;
    in_coeff = 16'hFFFF;   // idle value must be ignored
    check("load_beats", i, 256);
    check("in_ready_after_load", in_ready, 0);
    check("busy_after_load", busy, 1);
  endtask

  task automatic collect(input bit rand_ready, output int res[256],
                         output int first_cyc, output int last_cyc);
    int   n;
    int   budget;
    bit   r;
    bit   prev_stall;
    int   prev_c;
    int   prev_l;
    n = 0;
    budget = 0;
    prev_stall = 0;
    prev_c = 0;
    prev_l = 0;
    first_cyc = -1;
    last_cyc = -1;
    for (int i = 0; i < 256; i++) res[i] = -1;
    while (n < 256 && budget < 5000) begin
      budget++;
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (prev_stall) begin
          check("stall_coeff", out_coeff, prev_c);
          check("stall_last", out_last, prev_l);
        end
        r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        out_ready = r;
        if (r) begin
          res[n] = int'(out_coeff);
          check("out_last", out_last, (n == 255) ? 1 : 0);
          last_cyc = cyc;
          n++;
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          prev_c = int'(out_coeff);
          prev_l = int'(out_last);
        end
      end else begin
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
        prev_stall = 0;
      end
      tick();
    end
    out_ready = 1'b0;
    check("out_beats", n, 256);
    check("in_ready_after_out", in_ready, 1);
    check("busy_after_out", busy, 0);
    check("out_valid_after_out", out_valid, 0);
  endtask

  initial begin
    int c[256];
    int exp_r[256];
    int res[256];
    int t_last;
    int first_c;
    int last_c;

    for (int k = 0; k < 128; k++) begin
      int br;
      int p;
      br = 0;
      for (int b = 0; b < 7; b++) if (((k >> b) & 1) != 0) br = br | (1 << (6 - b));
      p = 1;
      for (int e = 0; e < br; e++) p = (p * 17) % Q;
      zt[k] = p;
    end

    // NTT(a + b*X) is (a, b) in every pair, so the inverse gives a, b, zeros.
    vecs[0] = '{"ones_even",   1,     0,     1,    0};
    vecs[1] = '{"ones_odd",    0,     1,     0,    1};
    vecs[2] = '{"all_zero",    0,     0,     0,    0};
    vecs[3] = '{"ffff_even",   65535, 0,     2284, 0};
    vecs[4] = '{"direct_2284", 2284,  0,     2284, 0};
    vecs[5] = '{"max_pair",    3328,  3328,  3328, 3328};
    vecs[6] = '{"q_multiples", 3329,  6658,  0,    0};
    vecs[7] = '{"mixed",       3328,  5,     3328, 5};

    reset = 1'b1;
    in_valid = 1'b0;
    in_coeff = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_out_coeff", out_coeff, 0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 256; i++) c[i] = (i % 2 == 0) ? vecs[v].even_in : vecs[v].odd_in;
      load_poly(c, 1'b0, t_last);
      collect(1'b0, res, first_c, last_c);
      check({vecs[v].name, "_latency"}, first_c, t_last + 897);
      check({vecs[v].name, "_burst"}, last_c - first_c, 255);
      check({vecs[v].name, "_c0"}, res[0], vecs[v].exp0);
      check({vecs[v].name, "_c1"}, res[1], vecs[v].exp1);
      for (int i = 2; i < 256; i++) check({vecs[v].name, "_rest"}, res[i], 0);
    end

    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < 256; i++) c[i] = int'($urandom_range(0, 65535));
      inv_ntt(c, exp_r);
      load_poly(c, 1'b1, t_last);
      collect(1'b1, res, first_c, last_c);
      check("rand_latency", first_c, t_last + 897);
      for (int i = 0; i < 256; i++) check("rand_coeff", res[i], exp_r[i]);
    end

    // Abort in the middle of COMPUTE, then make sure only the new load counts.
    for (int i = 0; i < 256; i++) c[i] = int'($urandom_range(0, Q - 1));
    load_poly(c, 1'b0, t_last);
    while (cyc < t_last + 400) tick();
    #2 reset = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (out_valid) check("abort_no_output", out_valid, 0);
    end
    check("abort_idle_ready", in_ready, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 256; i++) c[i] = int'($urandom_range(0, 65535));
    inv_ntt(c, exp_r);
    load_poly(c, 1'b1, t_last);
    collect(1'b1, res, first_c, last_c);
    check("abort_latency", first_c, t_last + 897);
    for (int i = 0; i < 256; i++) check("abort_coeff", res[i], exp_r[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
